// File: rtl/urisc_mem_resp.sv
// Memory responder for the urisc core: single-port word memory plus an LED register.
// Up to two requests may be outstanding, and responses return in order after a fixed latency.
package gc;
    parameter int WORD_SIZE = 16;
endpackage

module urisc_mem_resp #(
    parameter int WORD_SIZE = gc::WORD_SIZE,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int LED_ADDR  = DEPTH - 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AW-1:0]        req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_we,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic [WORD_SIZE-1:0] led
);

    localparam logic [AW-1:0] LED_A    = AW'(LED_ADDR);
    localparam logic [1:0]    TMR_INIT = 2'(LATENCY - 1);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Two-slot response queue; each slot counts down to its eligibility edge.
    logic                 slot_we_r   [2];
    logic [WORD_SIZE-1:0] slot_data_r [2];
    logic [1:0]           slot_tmr_r  [2];
    logic                 head_r;
    logic [1:0]           cnt_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic                 rsp_we_r;
    logic [WORD_SIZE-1:0] rsp_rdata_r;
    logic [WORD_SIZE-1:0] led_r;

    logic                 accept_s;
    logic                 consume_s;
    logic                 is_led_s;
    logic                 mem_we_s;
    logic [WORD_SIZE-1:0] cap_data_s;
    logic [1:0]           left_s;
    logic [1:0]           cnt_next_s;
    logic                 nhead_s;
    logic                 tail_s;
    logic                 present_s;
    logic                 rsp_we_next_s;
    logic [WORD_SIZE-1:0] rsp_rdata_next_s;

    // Handshakes, capture data and next queue state.
    always_comb begin
        accept_s  = req_valid & req_ready_r;
        consume_s = rsp_valid_r & rsp_ready;
        is_led_s  = (req_addr == LED_A);
        mem_we_s  = accept_s & req_we & ~is_led_s;
        if (req_we) begin
            cap_data_s = {WORD_SIZE{1'b0}};
        end else if (is_led_s) begin
            cap_data_s = led_r;
        end else begin
            cap_data_s = mem[req_addr];
        end
        // Entries left after a consume; a just-accepted entry is never eligible yet.
        left_s     = cnt_r - {1'b0, consume_s};
        cnt_next_s = left_s + {1'b0, accept_s};
        nhead_s    = head_r ^ consume_s;
        tail_s     = head_r ^ cnt_r[0];
        present_s  = (left_s != 2'd0) && (slot_tmr_r[nhead_s] == 2'd0);
        if (present_s) begin
            rsp_we_next_s    = slot_we_r[nhead_s];
            rsp_rdata_next_s = slot_data_r[nhead_s];
        end else begin
            rsp_we_next_s    = 1'b0;
            rsp_rdata_next_s = {WORD_SIZE{1'b0}};
        end
    end

    // Queue, response register, ready and LED state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_we_r[i]   <= 1'b0;
                slot_data_r[i] <= {WORD_SIZE{1'b0}};
                slot_tmr_r[i]  <= 2'd0;
            end
            head_r      <= 1'b0;
            cnt_r       <= 2'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_we_r    <= 1'b0;
            rsp_rdata_r <= {WORD_SIZE{1'b0}};
            led_r       <= {WORD_SIZE{1'b0}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept_s && (tail_s == 1'(i))) begin
                    slot_we_r[i]   <= req_we;
                    slot_data_r[i] <= cap_data_s;
                    slot_tmr_r[i]  <= TMR_INIT;
                end else if (slot_tmr_r[i] != 2'd0) begin
                    slot_tmr_r[i] <= slot_tmr_r[i] - 2'd1;
                end
            end
            head_r      <= nhead_s;
            cnt_r       <= cnt_next_s;
            req_ready_r <= (cnt_next_s < 2'd2);
            rsp_valid_r <= present_s;
            rsp_we_r    <= rsp_we_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
            if (accept_s && req_we && is_led_s) begin
                led_r <= req_wdata;
            end
        end
    end

    // Word storage; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[req_addr] <= req_wdata;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_we    = rsp_we_r;
    assign rsp_rdata = rsp_rdata_r;
    assign led       = led_r;

endmodule

// File: tb/tb_urisc_mem_resp.sv
// Bench for urisc_mem_resp: LATENCY=2 and LATENCY=4 instances checked every cycle
// against a request-timestamp queue model, plus a directed table and corner sequences.
module tb_urisc_mem_resp;
    localparam int W  = 16;
    localparam int D  = 256;
    localparam int AW = 8;
    localparam logic [AW-1:0] LED = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [1:0]            req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_we;
    logic [1:0][AW-1:0]    req_addr;
    logic [1:0][W-1:0]     req_wdata, rsp_rdata, led;

    urisc_mem_resp #(.WORD_SIZE(W), .DEPTH(D), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
        .rsp_rdata(rsp_rdata[0]), .led(led[0]));

    urisc_mem_resp #(.WORD_SIZE(W), .DEPTH(D), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
        .rsp_rdata(rsp_rdata[1]), .led(led[1]));

    typedef struct packed {
        logic         we;
        logic [W-1:0] data;
        logic         known;
        int           acc;
    } ent_t;

    typedef struct packed {
        logic v, we; logic [AW-1:0] a; logic [W-1:0] d; logic rr;
        logic x_ready, x_valid, x_we; logic [W-1:0] x_rdata, x_led;
    } vec_t;

    ent_t         mq [2][3];
    int           mn [2];
    logic [W-1:0] mm [2][D];
    bit           mk [2][D];
    logic [W-1:0] ml [2];
    logic         e_ready [2], e_valid [2], e_we [2], e_known [2];
    logic [W-1:0] e_rdata [2];
    int           lat [2];
    int           cyc, errors, checks;
    int           acc_d [2];
    logic [W-1:0] log0 [$];
    vec_t         tbl [9];

    task automatic chk(input string nm, input int i, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        mn[i] = 0; e_ready[i] = 1'b0; e_valid[i] = 1'b0; e_we[i] = 1'b0;
        e_rdata[i] = '0; e_known[i] = 1'b1; ml[i] = '0;
    endtask

    // One clock edge of the reference: accept/consume from the pre-edge view, then re-derive outputs.
    task automatic model_edge(input int i);
        bit a, c;
        ent_t e;
        if (!rst) begin
            model_reset(i);
            return;
        end
        a = req_valid[i] && e_ready[i];
        c = e_valid[i] && rsp_ready[i];
        if (c) begin
            for (int k = 0; k < mn[i] - 1; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
        end
        if (a) begin
            e.we = req_we[i]; e.acc = cyc;
            if (req_we[i]) begin
                e.data = '0; e.known = 1'b1;
                if (req_addr[i] == LED) ml[i] = req_wdata[i];
                else begin mm[i][req_addr[i]] = req_wdata[i]; mk[i][req_addr[i]] = 1'b1; end
            end else if (req_addr[i] == LED) begin
                e.data = ml[i]; e.known = 1'b1;
            end else begin
                e.data = mm[i][req_addr[i]]; e.known = mk[i][req_addr[i]];
            end
            mq[i][mn[i]] = e;
            mn[i]++;
        end
        e_valid[i] = (mn[i] > 0) && (cyc >= mq[i][0].acc + lat[i]);
        e_we[i]    = e_valid[i] ? mq[i][0].we : 1'b0;
        e_rdata[i] = e_valid[i] ? mq[i][0].data : '0;
        e_known[i] = e_valid[i] ? mq[i][0].known : 1'b1;
        e_ready[i] = (mn[i] < 2);
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("req_ready", i, W'(req_ready[i]), W'(e_ready[i]));
            chk("rsp_valid", i, W'(rsp_valid[i]), W'(e_valid[i]));
            chk("rsp_we", i, W'(rsp_we[i]), W'(e_we[i]));
            if (e_known[i]) chk("rsp_rdata", i, rsp_rdata[i], e_rdata[i]);
            chk("led", i, led[i], ml[i]);
        end
    endtask

    task automatic step();
        if (rsp_valid[0] && rsp_ready[0]) log0.push_back(rsp_rdata[0]);
        for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) acc_d[i]++;
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic set_in(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input bit rr);
        req_valid[i] = v; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; rsp_ready[i] = rr;
    endtask

    // Hold a request until the model says it is accepted, within a cycle budget.
    task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d, input bit rr);
        bit done;
        done = 1'b0;
        set_in(i, 1'b1, we, a, d, rr);
        for (int n = 0; n < 20 && !done; n++) begin
            done = e_ready[i];
            step();
        end
        req_valid[i] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout inst%0d addr=%h got=not accepted want=accepted", i, a);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0;
        lat[0] = 2; lat[1] = 4;
        acc_d[0] = 0; acc_d[1] = 0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(i, 1'b0, 1'b0, '0, '0, 1'b1);
            model_reset(i);
        end
        tbl[0] = '{1'b1, 1'b1, 8'h05, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00A5, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0003};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0003};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003};

        // Reset state, then release between edges.
        idle(2);
        #2 rst = 1'b1;
        step();

        // Directed table: write/read-back latency and LED register.
        for (int r = 0; r < 9; r++) begin
            set_in(0, tbl[r].v, tbl[r].we, tbl[r].a, tbl[r].d, tbl[r].rr);
            step();
            chk("tbl_ready", r, W'(req_ready[0]), W'(tbl[r].x_ready));
            chk("tbl_valid", r, W'(rsp_valid[0]), W'(tbl[r].x_valid));
            chk("tbl_we", r, W'(rsp_we[0]), W'(tbl[r].x_we));
            chk("tbl_rdata", r, rsp_rdata[0], tbl[r].x_rdata);
            chk("tbl_led", r, led[0], tbl[r].x_led);
        end
        set_in(0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Stalled responder: third read held, then in-order drain.
        issue(0, 1'b1, 8'd1, 16'h1111, 1'b1);
        issue(0, 1'b1, 8'd2, 16'h2222, 1'b1);
        issue(0, 1'b1, 8'd3, 16'h3333, 1'b1);
        idle(4);
        log0.delete();
        set_in(0, 1'b1, 1'b0, 8'd1, '0, 1'b0); step();
        set_in(0, 1'b1, 1'b0, 8'd2, '0, 1'b0); step();
        set_in(0, 1'b1, 1'b0, 8'd3, '0, 1'b0);
        idle(4);
        chk("stall_ready", 0, W'(req_ready[0]), 16'h0000);
        chk("stall_valid", 0, W'(rsp_valid[0]), 16'h0001);
        chk("stall_hold", 0, rsp_rdata[0], 16'h1111);
        issue(0, 1'b0, 8'd3, '0, 1'b1);
        idle(6);
        chk("order_n", 0, W'(log0.size()), 16'd3);
        if (log0.size() == 3) begin
            chk("order_0", 0, log0[0], 16'h1111);
            chk("order_1", 0, log0[1], 16'h2222);
            chk("order_2", 0, log0[2], 16'h3333);
        end

        // Asynchronous reset with two responses outstanding.
        issue(0, 1'b1, LED, 16'h00C3, 1'b1);
        idle(4);
        issue(0, 1'b1, 8'd7, 16'h0707, 1'b0);
        issue(0, 1'b1, 8'd8, 16'h0808, 1'b0);
        #2 rst = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        chk("arst_valid", 0, W'(rsp_valid[0]), 16'h0000);
        chk("arst_led", 0, led[0], 16'h0000);
        chk("arst_ready", 0, W'(req_ready[0]), 16'h0000);
        idle(2);
        #2 rst = 1'b1;
        rsp_ready[0] = 1'b1;
        step();
        chk("rel_ready", 0, W'(req_ready[0]), 16'h0001);
        idle(6);
        log0.delete();
        issue(0, 1'b0, 8'd7, '0, 1'b1);
        issue(0, 1'b0, 8'd8, '0, 1'b1);
        idle(5);
        chk("keep_n", 0, W'(log0.size()), 16'd2);
        if (log0.size() == 2) begin
            chk("keep_7", 0, log0[0], 16'h0707);
            chk("keep_8", 0, log0[1], 16'h0808);
        end

        // LATENCY=4 continuous reads: throttled by the two-outstanding limit.
        for (int a = 0; a < 4; a++) issue(1, 1'b1, AW'(a), W'(16'h4000 + a), 1'b1);
        idle(8);
        acc_d[1] = 0;
        for (int k = 0; k < 36; k++) begin
            set_in(1, 1'b1, 1'b0, AW'(k % 4), '0, 1'b1);
            step();
        end
        set_in(1, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(8);
        chk("l4_accepts", 1, W'(acc_d[1]), 16'd12);

        // Randomized traffic on both instances.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                int r;
                r = $urandom_range(0, 8);
                set_in(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                       (r == 8) ? LED : AW'(r), W'($urandom), $urandom_range(0, 99) < 70);
            end
            step();
        end
        for (int i = 0; i < 2; i++) set_in(i, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
